conv_addr_gen: RTL

- Parametrised successor of the single-configuration convolution controller.
- Walks every output pixel of a 2-D multi-channel convolution and issues one source-pixel address and one weight address per MAC tap.
- Flags accumulator clear at window start and window completion, with the output address.
- Sits between the feature/weight memories and the MAC/accumulator datapath, started by a top-level sequencer.

---
 rtl/conv_addr_gen_if.sv | 14 +
 rtl/conv_addr_gen.sv | 108 ++++++++++
 2 files changed

// File: rtl/conv_addr_gen_if.sv
// conv_addr_gen_if: run enable plus the tap address/flag stream of conv_addr_gen.
interface conv_addr_gen_if #(parameter int ADDR_W = 16);
  logic              en_ctrl;
  logic [ADDR_W-1:0] s_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] o_addr;
  logic              en_sum;
  logic              acc_clr;
  logic              win_done;
  logic              pad_zero;
  logic              finish;
  modport master (output en_ctrl, input s_addr, w_addr, o_addr, en_sum, acc_clr, win_done, pad_zero, finish);
  modport slave  (input en_ctrl, output s_addr, w_addr, o_addr, en_sum, acc_clr, win_done, pad_zero, finish);
endinterface

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: convolution tap address generator, loop order kx, ky, c, ox, oy.
// Define CONV_PAD_EN for "same" convolution with zero padding of K/2.
module conv_addr_gen #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int CH     = 1,
  parameter int ADDR_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  conv_addr_gen_if.slave bus
);
`ifdef CONV_PAD_EN
  localparam int OUT_W = (IMG_W + STRIDE - 1) / STRIDE;
  localparam int OUT_H = (IMG_H + STRIDE - 1) / STRIDE;
  localparam logic signed [ADDR_W+1:0] PS  = (ADDR_W+2)'(K / 2);
  localparam logic signed [ADDR_W+1:0] IWS = (ADDR_W+2)'(IMG_W);
  localparam logic signed [ADDR_W+1:0] IHS = (ADDR_W+2)'(IMG_H);
  logic signed [ADDR_W+1:0] x, y;
`else
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
`endif
  localparam logic [ADDR_W-1:0] KM  = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] CM  = ADDR_W'(CH - 1);
  localparam logic [ADDR_W-1:0] OWM = ADDR_W'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] OHM = ADDR_W'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] KA  = ADDR_W'(K);
  localparam logic [ADDR_W-1:0] KK  = ADDR_W'(K * K);
  localparam logic [ADDR_W-1:0] ST  = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] IW  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] PL  = ADDR_W'(IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] OW  = ADDR_W'(OUT_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0] kx, ky, c, ox, oy;
  logic [ADDR_W-1:0] xu, yu, s_nx, w_nx, o_nx;
  logic last_q, issue, pad;
  logic kx_end, ky_end, c_end, ox_end, oy_end, win_end, all_end;

  always_ff @(posedge clk) state <= !reset ? IDLE : state_nx;

  // last_q marks that the final tap is on the outputs, so the next run edge ends the image
  always_comb begin
    issue = bus.en_ctrl && (state == IDLE || (state == RUN && !last_q));
    state_nx = state == IDLE ? (bus.en_ctrl ? RUN : IDLE) :
               state == RUN  ? (bus.en_ctrl && last_q ? DONE : RUN) :
                               (bus.en_ctrl ? DONE : IDLE);
  end

  always_comb begin
    kx_end  = kx == KM;
    ky_end  = ky == KM;
    c_end   = c == CM;
    ox_end  = ox == OWM;
    oy_end  = oy == OHM;
    win_end = kx_end && ky_end && c_end;
    all_end = win_end && ox_end && oy_end;
    xu      = ox * ST + kx;
    yu      = oy * ST + ky;
    w_nx    = c * KK + ky * KA + kx;
    o_nx    = oy * OW + ox;
`ifdef CONV_PAD_EN
    x    = $signed({2'b00, xu}) - PS;
    y    = $signed({2'b00, yu}) - PS;
    pad  = x[ADDR_W+1] || x >= IWS || y[ADDR_W+1] || y >= IHS;
    s_nx = pad ? '0 : c * PL + y[ADDR_W-1:0] * IW + x[ADDR_W-1:0];
`else
    pad  = 1'b0;
    s_nx = c * PL + yu * IW + xu;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      {kx, ky, c, ox, oy} <= '0;
      {bus.s_addr, bus.w_addr, bus.o_addr} <= '0;
      {bus.en_sum, bus.acc_clr, bus.win_done, bus.pad_zero, last_q} <= '0;
    end else if (issue) begin
      kx           <= kx_end ? '0 : kx + 1'b1;
      ky           <= kx_end ? (ky_end ? '0 : ky + 1'b1) : ky;
      c            <= kx_end && ky_end ? (c_end ? '0 : c + 1'b1) : c;
      ox           <= win_end ? (ox_end ? '0 : ox + 1'b1) : ox;
      oy           <= win_end && ox_end ? (oy_end ? '0 : oy + 1'b1) : oy;
      bus.s_addr   <= s_nx;
      bus.w_addr   <= w_nx;
      bus.o_addr   <= o_nx;
      bus.en_sum   <= 1'b1;
      bus.acc_clr  <= kx == '0 && ky == '0 && c == '0;
      bus.win_done <= win_end;
      bus.pad_zero <= pad;
      last_q       <= all_end;
    end else begin
      {bus.en_sum, bus.acc_clr, bus.win_done, bus.pad_zero} <= '0;
      if (state_nx == IDLE) begin
        {kx, ky, c, ox, oy} <= '0;
        {bus.s_addr, bus.w_addr, bus.o_addr} <= '0;
        last_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) bus.finish <= reset && state_nx == DONE;
endmodule
